vec_packer: RTL and testbench

VEC_PACKER -- requirements
Module: vec_packer

---
 rtl/vec_packer.sv | 113 +++++++++++
 tb/tb_vec_packer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vec_packer.sv
// Serial-to-vector packer: clamps 12-bit signed samples to +/-SAT_MAX and
// assembles groups of four into a registered 8-bit vector with valid/ready.
module vec_packer #(
    parameter int SAT_MAX = 127
) (
    input  logic              clk,
    input  logic              arst,
    input  logic signed [11:0] in_data,
    input  logic              in_sof,
    input  logic              in_valid,
    output logic              in_ready,
    output logic signed [7:0] X1,
    output logic signed [7:0] X2,
    output logic signed [7:0] X3,
    output logic signed [7:0] X4,
    output logic              valid,
    input  logic              ready,
    output logic              sat,
    output logic [7:0]        drop_cnt
);

    localparam int unsigned IN_W  = 12;
    localparam int unsigned EL_W  = 8;
    localparam int unsigned N_EL  = 4;

    localparam logic signed [IN_W-1:0] SAT_HI  = IN_W'(SAT_MAX);
    localparam logic signed [IN_W-1:0] SAT_LO  = IN_W'(-SAT_MAX);
    localparam logic        [EL_W-1:0] POS_EL  = EL_W'(SAT_MAX);
    localparam logic        [EL_W-1:0] NEG_EL  = EL_W'(-SAT_MAX);
    localparam logic        [EL_W-1:0] CNT_MAX = '1;

    logic [1:0]      idx;
    logic            asm_full;
    logic            asm_sat;
    logic [EL_W-1:0] a_buf [N_EL];

    logic            transfer_c;
    logic            accept_c;
    logic            resync_c;
    logic            clip_c;
    logic [EL_W-1:0] samp_c;

    // Handshake decode and per-sample clamp
    always_comb begin
        transfer_c = asm_full && (!valid || ready);
        in_ready   = !asm_full || transfer_c;
        accept_c   = in_valid && in_ready;
        resync_c   = accept_c && in_sof && (idx != 2'd0);
        clip_c     = 1'b0;
        samp_c     = in_data[EL_W-1:0];
        if (in_data > SAT_HI) begin
            clip_c = 1'b1;
            samp_c = POS_EL;
        end else if (in_data < SAT_LO) begin
            clip_c = 1'b1;
            samp_c = NEG_EL;
        end
    end

    // Output register: transfer loads the assembled vector, handshake drains it
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            X1    <= '0;
            X2    <= '0;
            X3    <= '0;
            X4    <= '0;
            sat   <= 1'b0;
            valid <= 1'b0;
        end else if (transfer_c) begin
            X1    <= a_buf[0];
            X2    <= a_buf[1];
            X3    <= a_buf[2];
            X4    <= a_buf[3];
            sat   <= asm_sat;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

    // Assembly buffer; a new A1 may be written while a transfer reads the old one
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            idx      <= 2'd0;
            asm_full <= 1'b0;
            asm_sat  <= 1'b0;
            drop_cnt <= '0;
            for (int i = 0; i < int'(N_EL); i++) begin
                a_buf[i] <= '0;
            end
        end else begin
            if (transfer_c) begin
                asm_full <= 1'b0;
            end
            if (resync_c) begin
                a_buf[0] <= samp_c;
                idx      <= 2'd1;
                asm_sat  <= clip_c;
                if (drop_cnt != CNT_MAX) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end else if (accept_c) begin
                a_buf[idx] <= samp_c;
                asm_sat    <= (idx == 2'd0) ? clip_c : (asm_sat | clip_c);
                idx        <= idx + 2'd1;
                if (idx == 2'd3) begin
                    asm_full <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vec_packer.sv
// Directed self-checking bench for vec_packer: hand-computed vectors for
// basic packing, clamping, backpressure, resync, throughput and reset.
module tb_vec_packer;

    logic              clk = 1'b0;
    logic              arst;
    logic signed [11:0] in_data;
    logic              in_sof;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] X1, X2, X3, X4;
    logic              valid;
    logic              ready;
    logic              sat;
    logic [7:0]        drop_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int stalls = 0;
    logic [32:0] outq [$];

    vec_packer #(.SAT_MAX(127)) dut (
        .clk      (clk),
        .arst     (arst),
        .in_data  (in_data),
        .in_sof   (in_sof),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .X1       (X1),
        .X2       (X2),
        .X3       (X3),
        .X4       (X4),
        .valid    (valid),
        .ready    (ready),
        .sat      (sat),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output handshake and any input stall, mid-cycle
    always @(negedge clk) begin
        if (valid && ready) outq.push_back({X1, X2, X3, X4, sat});
        if (in_valid && !in_ready) stalls <= stalls + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and hold it until accepted (bounded)
    task automatic send(input int val, input logic sof);
        logic acc;
        in_valid = 1'b1;
        in_data  = 12'(val);
        in_sof   = sof;
        acc      = 1'b0;
        for (int n = 0; n < 100 && !acc; n++) begin
            acc = in_ready;
            step();
        end
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send4(input int a, input int b, input int c, input int d);
        send(a, 1'b1);
        send(b, 1'b0);
        send(c, 1'b0);
        send(d, 1'b0);
    endtask

    task automatic chk_vec(input string tag, input int a, input int b,
                           input int c, input int d, input int s);
        chk({tag, "_x1"}, int'(X1), a);
        chk({tag, "_x2"}, int'(X2), b);
        chk({tag, "_x3"}, int'(X3), c);
        chk({tag, "_x4"}, int'(X4), d);
        chk({tag, "_sat"}, int'(sat), s);
    endtask

    function automatic int el(input logic [32:0] v, input int k);
        logic [7:0] b;
        b = v[32-8*k -: 8];
        return int'($signed(b));
    endfunction

    initial begin
        int c0;
        logic [32:0] v;
        arst     = 1'b1;
        in_data  = '0;
        in_sof   = 1'b0;
        in_valid = 1'b0;
        ready    = 1'b1;
        step();
        step();

        // Reset state
        chk("rst_valid", int'(valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_drop", int'(drop_cnt), 0);
        chk_vec("rst", 0, 0, 0, 0, 0);
        arst = 1'b0;

        // Basic vector, one-cycle latency after the 4th handshake
        send4(5, -3, 100, -100);
        chk("basic_lat0", int'(valid), 0);
        step();
        chk("basic_valid", int'(valid), 1);
        chk_vec("basic", 5, -3, 100, -100, 0);
        step();
        chk("basic_drain", int'(valid), 0);

        // Clamping and sticky-flag restart
        send4(300, -2048, -128, 127);
        step();
        chk("clamp_valid", int'(valid), 1);
        chk_vec("clamp", 127, -127, -127, 127, 1);
        send4(1, 2, 3, 4);
        step();
        chk_vec("clamp_next", 1, 2, 3, 4, 0);
        step();

        // Throughput: 40 samples in 40 cycles, 10 vectors, no stalls
        outq.delete();
        stalls = 0;
        c0 = cyc;
        for (int i = 0; i < 40; i++) send(i - 20, (i % 4) == 0);
        chk("tput_cycles", cyc - c0, 40);
        step();
        step();
        chk("tput_vectors", outq.size(), 10);
        chk("tput_stalls", stalls, 0);
        if (outq.size() == 10) begin
            v = outq[9];
            chk("tput_v9_x1", el(v, 0), 16);
            chk("tput_v9_x4", el(v, 3), 19);
        end

        // Backpressure: two vectors streamed with ready low
        ready = 1'b0;
        outq.delete();
        for (int i = 0; i < 8; i++) send(11 + i, (i % 4) == 0);
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_valid", int'(valid), 1);
        chk_vec("bp_hold0", 11, 12, 13, 14, 0);
        step();
        step();
        step();
        chk_vec("bp_hold3", 11, 12, 13, 14, 0);
        chk("bp_in_ready3", int'(in_ready), 0);
        ready = 1'b1;
        step();
        chk("bp_second_valid", int'(valid), 1);
        chk_vec("bp_second", 15, 16, 17, 18, 0);
        step();
        chk("bp_drain", int'(valid), 0);
        chk("bp_count", outq.size(), 2);
        if (outq.size() == 2) begin
            v = outq[0];
            chk("bp_q0_x4", el(v, 3), 14);
            v = outq[1];
            chk("bp_q1_x1", el(v, 0), 15);
        end

        // Resync discards a partial vector
        send(1, 1'b1);
        send(2, 1'b0);
        send(9, 1'b1);
        chk("resync_drop", int'(drop_cnt), 1);
        send(8, 1'b0);
        send(7, 1'b0);
        send(6, 1'b0);
        step();
        chk_vec("resync", 9, 8, 7, 6, 0);
        step();

        // Repeated sof: first is a normal X1, each later one is a drop
        for (int i = 0; i < 10; i++) send(1, 1'b1);
        chk("resync_10", int'(drop_cnt), 10);
        for (int i = 0; i < 290; i++) send(1, 1'b1);
        chk("resync_sat", int'(drop_cnt), 255);
        send(1, 1'b1);
        chk("resync_hold", int'(drop_cnt), 255);

        // Reset mid-vector, then a clean vector
        arst = 1'b1;
        #1;
        chk("rst2_drop", int'(drop_cnt), 0);
        arst = 1'b0;
        send(20, 1'b1);
        send(21, 1'b0);
        arst = 1'b1;
        #1;
        chk("rst3_valid", int'(valid), 0);
        chk("rst3_drop", int'(drop_cnt), 0);
        chk("rst3_in_ready", int'(in_ready), 1);
        step();
        arst = 1'b0;
        send4(30, 31, 32, 33);
        chk("rst3_lat", int'(valid), 0);
        step();
        chk("rst3_valid_after", int'(valid), 1);
        chk_vec("rst3_vec", 30, 31, 32, 33, 0);
        chk("rst3_drop_after", int'(drop_cnt), 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
